// File: rtl/mux_arbiter_5.sv
// Five-way round-robin arbiter that captures the winning requester's data into
// a registered output and holds it under valid/ready handshake until accepted.
module mux_arbiter_5 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      req,
    input  logic [5*DW-1:0] in_data,
    output logic [4:0]      req_ack,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      selection,
    output logic            busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state;
    logic [2:0]    ptr;
    logic [DW-1:0] chan [5];
    logic [2:0]    winner;
    logic          found;
    logic [3:0]    scan;

    for (genvar g = 0; g < 5; g++) begin : g_chan
        assign chan[g] = in_data[DW*g +: DW];
    end

    // Scan from ptr upward with wrap 4 -> 0; the first set request wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        found  = 1'b0;
        winner = 3'd0;
        scan   = 4'd0;
        for (int k = 0; k < 5; k++) begin
            scan = {1'b0, ptr} + 4'(k);
            if (scan >= 4'd5) begin
                scan = scan - 4'd5;
            end
            if (!found && req[scan[2:0]]) begin
                found  = 1'b1;
                winner = scan[2:0];
            end
        end
    end

    // The ack is only meaningful when the capture edge will actually take the data.
    assign req_ack = (!reset && state == IDLE && found) ? (5'b00001 << winner) : 5'b00000;
    assign busy    = (state == SEND);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: reset clears the data/selection registers too, because the outputs
        // must read zero immediately, before any further clock edge.
        if (reset) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            selection <= 3'd0;
        end else if (state == IDLE) begin
            // NOTE: sequential state uses non-blocking assignments so all registers
            // update from the same pre-edge values.
            if (found) begin
                out_data  <= chan[winner];
                selection <= winner;
                out_valid <= 1'b1;
                state     <= SEND;
            end
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
                ptr       <= (selection == 3'd4) ? 3'd0 : selection + 3'd1;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mux_arbiter_5.sv
// Bench for mux_arbiter_5: directed scenarios plus random traffic, each cycle
// compared against a transaction-level model of the arbitration rules.
module tb_mux_arbiter_5;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      req;
    logic [5*DW-1:0] in_data;
    logic [4:0]      req_ack;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [2:0]      selection;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // Transaction-level model
    bit            m_busy;
    bit            m_valid;
    int            m_ptr;
    int            m_sel;
    logic [DW-1:0] m_data;
    logic [4:0]    ack_seen;

    mux_arbiter_5 #(.DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in_data   (in_data),
        .req_ack   (req_ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .selection (selection),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [4:0] r, input int p);
        for (int k = 0; k < 5; k++) begin
            if (r[(p + k) % 5]) return (p + k) % 5;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] slice(input logic [5*DW-1:0] d, input int i);
        return d[DW*i +: DW];
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_ptr   = 0;
        m_sel   = 0;
        m_data  = '0;
    endtask

    // Called at a falling edge after inputs are set; checks ack, clocks, checks registers.
    task automatic cycle();
        int w;
        logic [4:0] eack;
        #1;
        w    = m_busy ? -1 : pick(req, m_ptr);
        eack = (w >= 0) ? (5'b00001 << w) : 5'b00000;
        ack_seen = req_ack;
        check("req_ack", {27'd0, req_ack}, {27'd0, eack});
        @(posedge clk);
        if (!m_busy) begin
            if (w >= 0) begin
                m_data  = slice(in_data, w);
                m_sel   = w;
                m_valid = 1'b1;
                m_busy  = 1'b1;
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_ptr   = (m_sel + 1) % 5;
        end
        @(negedge clk);
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("out_data", {24'd0, out_data}, {24'd0, m_data});
        check("selection", {29'd0, selection}, m_sel);
        check("busy", {31'd0, busy}, {31'd0, m_busy});
    endtask

    // Asserts reset between edges with requests pending; outputs must clear at once.
    task automatic apply_reset();
        req = 5'b11111;
        #2 reset = 1'b1;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_sel", {29'd0, selection}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {27'd0, req_ack}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = 5'b00000;
    endtask

    initial begin
        int rr_order[6];
        logic [DW-1:0] held_data;
        rr_order = '{0, 1, 2, 3, 4, 0};
        reset     = 1'b1;
        req       = 5'b00000;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single request from requester 2
        req     = 5'b00100;
        in_data = {8'h44, 8'h33, 8'hA5, 8'h11, 8'h00};
        cycle();
        check("single_ack", {27'd0, ack_seen}, 32'h04);
        check("single_data", {24'd0, out_data}, 32'hA5);
        check("single_sel", {29'd0, selection}, 32'd2);
        check("single_busy", {31'd0, busy}, 32'd1);
        req       = 5'b00000;
        out_ready = 1'b1;
        cycle();
        check("single_done", {30'd0, out_valid, busy}, 32'd0);

        // Round-robin with all requesting and downstream always ready
        apply_reset();
        req       = 5'b11111;
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            in_data = {$urandom, $urandom};
            cycle();
            if (n % 2 == 0) check("rr_grant", {27'd0, ack_seen}, 32'(5'b00001 << rr_order[n/2]));
            else            check("rr_gap", {27'd0, ack_seen}, 32'd0);
        end

        // Wrap with gap: grant 3, then ptr=4 and 4 not requesting -> 0, then 3
        apply_reset();
        req       = 5'b01000;
        out_ready = 1'b1;
        cycle();
        check("wrap_g3", {27'd0, ack_seen}, 32'h08);
        req = 5'b00000;
        cycle();
        req = 5'b01001;
        cycle();
        check("wrap_g0", {27'd0, ack_seen}, 32'h01);
        req = 5'b01000;
        cycle();
        cycle();
        check("wrap_g3b", {27'd0, ack_seen}, 32'h08);
        cycle();

        // Backpressure: 10 cycles stalled with everyone requesting
        apply_reset();
        req       = 5'b11111;
        out_ready = 1'b0;
        in_data   = {$urandom, $urandom};
        cycle();
        held_data = out_data;
        for (int n = 0; n < 10; n++) begin
            in_data   = {$urandom, $urandom};
            out_ready = 1'b0;
            cycle();
            check("bp_ack", {27'd0, ack_seen}, 32'd0);
        end
        check("bp_hold", {24'd0, out_data}, {24'd0, held_data});
        check("bp_sel", {29'd0, selection}, 32'd0);
        out_ready = 1'b1;
        cycle();
        cycle();
        check("bp_next", {27'd0, ack_seen}, 32'h02);

        // Mid-transfer reset while selection=3
        apply_reset();
        req       = 5'b01000;
        out_ready = 1'b0;
        in_data   = {$urandom, $urandom};
        cycle();
        check("mid_sel3", {29'd0, selection}, 32'd3);
        apply_reset();
        req = 5'b11000;
        cycle();
        check("mid_first", {27'd0, ack_seen}, 32'h08);
        out_ready = 1'b1;
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            req       = 5'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = 1'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_5.md
MUX_ARBITER_5 -- requirements
Module: mux_arbiter_5

Interface
REQ-001 Parameter: DW, default 8, data width of each requester channel and of the output.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  5  request from requester i on bit i; level, held until acked.
REQ-005 Port: in_data  input  5*DW  requester i data on bits [DW*i+DW-1 : DW*i].
REQ-006 Port: req_ack  output  5  one-hot acknowledge; bit i high means requester i's data is captured at this edge.
REQ-007 Port: out_valid  output  1  out_data/selection hold a transfer awaiting acceptance.
REQ-008 Port: out_ready  input  1  downstream accepts the transfer when high with out_valid.
REQ-009 Port: out_data  output  DW  registered data of the granted requester.
REQ-010 Port: selection  output  3  registered index (0..4) of the requester whose data is on out_data.
REQ-011 Port: busy  output  1  high while in state SEND.

Function
REQ-012 The block SHALL implement two states: IDLE and SEND; busy SHALL equal (state == SEND).
REQ-013 The block SHALL hold a 3-bit round-robin pointer ptr in range 0..4, indicating the highest-priority requester.
REQ-014 In IDLE with req != 0, the winner SHALL be the first set bit of req scanning ptr, ptr+1, ... with wrap 4 -> 0.
REQ-015 In IDLE with req != 0, req_ack SHALL combinationally assert only the winner's bit in that same cycle.
REQ-016 At that edge, out_data SHALL load the winner's slice and selection SHALL load the winner index. Also at that edge, out_valid SHALL become 1 and state SHALL become SEND.
REQ-017 In IDLE with req == 0, req_ack SHALL be 0 and all registers SHALL hold.
REQ-018 In SEND, req_ack SHALL be 0 and req SHALL be ignored; out_data and selection SHALL remain stable.
REQ-019 In SEND with out_ready == 1 at an edge, out_valid SHALL become 0, ptr SHALL become (selection+1) mod 5, and state SHALL become IDLE.
REQ-020 In SEND with out_ready == 0, out_valid SHALL stay 1 indefinitely; no timeout exists.
REQ-021 Minimum spacing SHALL be 2 cycles per transfer: one capture cycle, then at least one SEND cycle.
REQ-022 selection SHALL never take values 5..7; after a transfer completes, selection and out_data SHALL hold their last value.
REQ-023 out_ready while out_valid == 0 SHALL have no effect.
REQ-024 A requester dropping req before its ack SHALL simply be excluded from arbitration; no state is kept per requester.

Reset
REQ-025 On reset assertion, the following SHALL take effect immediately, independent of clk: state = IDLE, out_valid = 0, out_data = 0, selection = 3'd0, ptr = 0, busy = 0.
REQ-026 While reset is high, req_ack SHALL be 0.
REQ-027 Reset asserted during SEND SHALL discard the pending transfer; no ack or data is replayed after release.
REQ-028 The first edge after reset release SHALL arbitrate normally with ptr = 0.

Verification
REQ-029 Single request: after reset, req=5'b00100 with in_data slice2=8'hA5. Required response: req_ack=5'b00100 for one cycle; next cycle out_valid=1, out_data=8'hA5, selection=2, busy=1. With out_ready=1 one cycle later, out_valid=0 and busy=0.
REQ-030 Round-robin: req=5'b11111 held and out_ready=1 constant. Required response: grants in order 0,1,2,3,4,0, one every 2 cycles; req_ack one-hot each time.
REQ-031 Wrap with gap: ptr=4 after granting 3, then req=5'b01001. Required response: requester 0 is granted (4 not requesting, wraps to 0), then 3 on the next grant.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in SEND while req=5'b11111. Required response: out_valid=1 and out_data/selection stable; req_ack=0 throughout. On out_ready=1, one completion, then next grant.
REQ-033 Mid-transfer reset: assert reset asynchronously (between edges) in SEND with selection=3. Required response: out_valid=0, selection=0 and out_data=0 before next edge. After release with req=5'b11000, requester 3 is granted first (ptr=0 scan).
